// File: rtl/ctrl_reg_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_reg_pkg
// Shared definitions for the multimode control register:
//   - per-bit output mode encodings
//   - parameter legality bounds
//   - pulse_cnt_width(): width of a PULSE down-counter able to hold len
// ---------------------------------------------------------------------------
package ctrl_reg_pkg;

   localparam logic [1:0] MODE_DIRECT = 2'd0;
   localparam logic [1:0] MODE_SYNC   = 2'd1;
   localparam logic [1:0] MODE_TOGGLE = 2'd2;
   localparam logic [1:0] MODE_PULSE  = 2'd3;

   localparam int MAX_WIDTH     = 32;
   localparam int MAX_PULSE_LEN = 255;

   // Equivalent to $clog2(len + 1): number of bits needed to store len.
   function automatic int pulse_cnt_width(input int len);
      int w;
      w = 0;
      for (int k = 0; k < 32; k++) begin
         if ((1 << k) <= len) w = k + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/ctrl_pulse_bit.sv
// ---------------------------------------------------------------------------
// ctrl_pulse_bit
// One PULSE-mode control bit: a down-counter loaded with PulseLen on a
// trigger, decremented every edge while nonzero. The output is high while
// the counter is nonzero, i.e. for exactly PulseLen cycles after the load
// edge. A trigger while already running reloads the counter.
// Ports:
//   clock   in  block clock
//   reset   in  asynchronous active-low reset (counter -> 0)
//   clr     in  synchronous clear (counter -> 0), dominates load
//   load    in  trigger, sampled on clock edge
//   active  out counter != 0
// ---------------------------------------------------------------------------
module ctrl_pulse_bit
   import ctrl_reg_pkg::*;
#(
   parameter int PulseLen = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic load,
   output logic active
);

   localparam int CntW = pulse_cnt_width(PulseLen);

   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= CntW'(PulseLen);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CntW'(1);
      end
   end

   assign active = (cnt_q != '0);

endmodule

// File: rtl/ctrl_reg_multimode.sv
// ---------------------------------------------------------------------------
// ctrl_reg_multimode
// CPU-written control register, 1..32 bits, each bit with its own output
// mode selected at elaboration by {ModeMask1[i], ModeMask0[i]}:
//   DIRECT : control = shadow bit (new value visible from the write edge)
//   SYNC   : control = shadow bit delayed by one register stage
//   TOGGLE : writing 1 inverts the shadow bit, writing 0 does nothing
//   PULSE  : writing 1 (re)starts a PulseLen-cycle high pulse
// Ports:
//   clock       in  block clock, rising edge
//   reset       in  asynchronous active-low reset
//   wr_en       in  write strobe
//   wr_data     in  [Width] write data
//   wr_mask     in  [Width] per-bit write enable (qualified by wr_en)
//   ext_clr     in  synchronous clear to init state (only if ExtReset=1)
//   control     out [Width] control outputs
//   rd_data     out [Width] readback (SYNC bits read the pre-stage shadow)
//   pulse_busy  out OR of all active PULSE bits
// ---------------------------------------------------------------------------
module ctrl_reg_multimode
   import ctrl_reg_pkg::*;
#(
   parameter int               Width     = 8,
   parameter logic [Width-1:0] ModeMask0 = {Width{1'b0}},
   parameter logic [Width-1:0] ModeMask1 = {Width{1'b0}},
   parameter logic [Width-1:0] InitValue = {Width{1'b0}},
   parameter int               PulseLen  = 1,
   parameter bit               ExtReset  = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [Width-1:0] wr_data,
   input  logic [Width-1:0] wr_mask,
   input  logic             ext_clr,
   output logic [Width-1:0] control,
   output logic [Width-1:0] rd_data,
   output logic             pulse_busy
);

   if (Width < 1 || Width > MAX_WIDTH) begin : g_bad_width
      $fatal(1, "ctrl_reg_multimode: Width must be in 1..32");
   end
   if (PulseLen < 1 || PulseLen > MAX_PULSE_LEN) begin : g_bad_pulse_len
      $fatal(1, "ctrl_reg_multimode: PulseLen must be in 1..255");
   end

   // Clear is folded to a constant 0 when the feature is disabled.
   logic clr;
   assign clr = ExtReset && ext_clr;

   logic [Width-1:0] ctrl_w;
   logic [Width-1:0] rd_w;
   logic [Width-1:0] pulse_w;

   for (genvar i = 0; i < Width; i++) begin : g_bit
      localparam logic [1:0] Mode = {ModeMask1[i], ModeMask0[i]};

      logic we;
      assign we = wr_en & wr_mask[i];

      if (Mode == MODE_PULSE) begin : g_pulse
         logic act;

         ctrl_pulse_bit #(
            .PulseLen (PulseLen)
         ) u_pulse (
            .clock  (clock),
            .reset  (reset),
            .clr    (clr),
            .load   (we & wr_data[i]),
            .active (act)
         );

         // InitValue is deliberately ignored here: pulses always idle low.
         assign ctrl_w[i]  = act;
         assign rd_w[i]    = act;
         assign pulse_w[i] = act;
      end else begin : g_level
         logic shadow_q;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               shadow_q <= InitValue[i];
            end else if (clr) begin
               shadow_q <= InitValue[i];
            end else if (we) begin
               if (Mode == MODE_TOGGLE) shadow_q <= shadow_q ^ wr_data[i];
               else                     shadow_q <= wr_data[i];
            end
         end

         if (Mode == MODE_SYNC) begin : g_sync
            logic stage_q;

            // The stage is cleared alongside the shadow so control shows the
            // init value from the clear edge, not one cycle later.
            always_ff @(posedge clock or negedge reset) begin
               if (!reset) begin
                  stage_q <= InitValue[i];
               end else if (clr) begin
                  stage_q <= InitValue[i];
               end else begin
                  stage_q <= shadow_q;
               end
            end

            assign ctrl_w[i] = stage_q;
         end else begin : g_nosync
            assign ctrl_w[i] = shadow_q;
         end

         assign rd_w[i]    = shadow_q;
         assign pulse_w[i] = 1'b0;
      end
   end

   assign control    = ctrl_w;
   assign rd_data    = rd_w;
   assign pulse_busy = |pulse_w;

endmodule

// File: tb/tb_ctrl_reg_multimode.sv
// ---------------------------------------------------------------------------
// tb_ctrl_reg_multimode
// Three instances share one stimulus stream:
//   dut_a  : InitValue=8'h11, ExtReset=1 (main configuration)
//   dut_d1 : InitValue=8'hD1, ExtReset=1 (PULSE init bits must be ignored)
//   dut_nx : InitValue=8'h11, ExtReset=0 (ext_clr must be ignored)
// Bits 1:0 DIRECT, 3:2 SYNC, 5:4 TOGGLE, 7:6 PULSE; PulseLen=3.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ctrl_reg_multimode;

   localparam int         W   = 8;
   localparam logic [7:0] MM0 = 8'hCC;
   localparam logic [7:0] MM1 = 8'hF0;

   logic         clock;
   logic         reset;
   logic         wr_en;
   logic [W-1:0] wr_data;
   logic [W-1:0] wr_mask;
   logic         ext_clr;

   logic [W-1:0] ctl_a, rd_a, ctl_d1, rd_d1, ctl_nx, rd_nx;
   logic         busy_a, busy_d1, busy_nx;

   int tests_run;
   int tests_failed;

   ctrl_reg_multimode #(
      .Width(W), .ModeMask0(MM0), .ModeMask1(MM1),
      .InitValue(8'h11), .PulseLen(3), .ExtReset(1'b1)
   ) dut_a (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .wr_mask(wr_mask), .ext_clr(ext_clr), .control(ctl_a),
      .rd_data(rd_a), .pulse_busy(busy_a)
   );

   ctrl_reg_multimode #(
      .Width(W), .ModeMask0(MM0), .ModeMask1(MM1),
      .InitValue(8'hD1), .PulseLen(3), .ExtReset(1'b1)
   ) dut_d1 (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .wr_mask(wr_mask), .ext_clr(ext_clr), .control(ctl_d1),
      .rd_data(rd_d1), .pulse_busy(busy_d1)
   );

   ctrl_reg_multimode #(
      .Width(W), .ModeMask0(MM0), .ModeMask1(MM1),
      .InitValue(8'h11), .PulseLen(3), .ExtReset(1'b0)
   ) dut_nx (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .wr_mask(wr_mask), .ext_clr(ext_clr), .control(ctl_nx),
      .rd_data(rd_nx), .pulse_busy(busy_nx)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Called at a falling edge; leaves the write applied to exactly one
   // rising edge and returns at the following falling edge.
   task automatic do_write(input logic [W-1:0] d, input logic [W-1:0] m);
      wr_en   = 1'b1;
      wr_data = d;
      wr_mask = m;
      @(negedge clock);
      wr_en   = 1'b0;
      wr_data = '0;
      wr_mask = '0;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      // Disturb every mode first, then assert reset mid-cycle.
      do_write(8'hFF, 8'hFF);
      #2 reset = 1'b0;
      #1;
      tests_run++;
      if (ctl_a !== 8'h11 || rd_a !== 8'h11 || busy_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_async: control=%h rd=%h busy=%b, need 11 11 0", ctl_a, rd_a, busy_a);
      end
      tests_run++;
      if (ctl_d1 !== 8'h11 || rd_d1 !== 8'h11 || busy_d1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_init_d1: control=%h rd=%h busy=%b, need 11 11 0", ctl_d1, rd_d1, busy_d1);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      tests_run++;
      if (ctl_a !== 8'h11 || rd_a !== 8'h11) begin
         tests_failed++;
         $display("FAIL reset_release: control=%h rd=%h, need 11 11", ctl_a, rd_a);
      end
   endtask

   task automatic test_direct_sync();
      do_write(8'h0E, 8'h0F);   // edge N
      tests_run++;
      if (ctl_a[1:0] !== 2'b10 || ctl_a[3:2] !== 2'b00 || rd_a[3:0] !== 4'hE) begin
         tests_failed++;
         $display("FAIL direct_sync_n: control=%h rd=%h, need [1:0]=10 [3:2]=00 rd[3:0]=e", ctl_a, rd_a);
      end
      tests_run++;
      if (ctl_a[7:4] !== 4'h1) begin
         tests_failed++;
         $display("FAIL unmasked_bits: control[7:4]=%h, need 1", ctl_a[7:4]);
      end
      @(negedge clock);        // after N+1
      tests_run++;
      if (ctl_a !== 8'h1E || rd_a !== 8'h1E) begin
         tests_failed++;
         $display("FAIL direct_sync_n1: control=%h rd=%h, need 1e 1e", ctl_a, rd_a);
      end
      // Strobe low: data and mask must be ignored.
      wr_en = 1'b0; wr_data = 8'hFF; wr_mask = 8'hFF;
      @(negedge clock);
      @(negedge clock);
      wr_data = '0; wr_mask = '0;
      tests_run++;
      if (ctl_a !== 8'h1E || busy_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL wr_en_low: control=%h busy=%b, need 1e 0", ctl_a, busy_a);
      end
   endtask

   task automatic test_toggle();
      do_write(8'h30, 8'h30);  // edge N: 01 -> 10
      tests_run++;
      if (ctl_a[5:4] !== 2'b10 || rd_a[5:4] !== 2'b10) begin
         tests_failed++;
         $display("FAIL toggle_n: control[5:4]=%b rd[5:4]=%b, need 10", ctl_a[5:4], rd_a[5:4]);
      end
      @(negedge clock);
      @(negedge clock);        // after N+2
      tests_run++;
      if (ctl_a[5:4] !== 2'b10) begin
         tests_failed++;
         $display("FAIL toggle_hold: control[5:4]=%b, need 10", ctl_a[5:4]);
      end
      do_write(8'h30, 8'h30);  // edge N+3: 10 -> 01
      tests_run++;
      if (ctl_a[5:4] !== 2'b01) begin
         tests_failed++;
         $display("FAIL toggle_n3: control[5:4]=%b, need 01", ctl_a[5:4]);
      end
      do_write(8'h00, 8'h30);  // zeros do nothing
      tests_run++;
      if (ctl_a[5:4] !== 2'b01 || ctl_a !== 8'h1E) begin
         tests_failed++;
         $display("FAIL toggle_zero: control=%h, need 1e", ctl_a);
      end
   endtask

   task automatic test_pulse();
      logic [3:0] exp_seq;
      // Single pulse: high after N, N+1, N+2; low after N+3.
      exp_seq = 4'b0111;
      do_write(8'h40, 8'h40);
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (ctl_a[6] !== exp_seq[k] || busy_a !== exp_seq[k] || rd_a[6] !== exp_seq[k] || ctl_a[7] !== 1'b0) begin
            tests_failed++;
            $display("FAIL pulse_single[%0d]: control=%h busy=%b, need bit6=%b", k, ctl_a, busy_a, exp_seq[k]);
         end
         @(negedge clock);
      end
      // Retrigger at N+2 extends the pulse through N+4, low after N+5.
      do_write(8'h40, 8'h40);  // N
      @(negedge clock);        // after N+1
      do_write(8'h40, 8'h40);  // N+2
      for (int k = 0; k < 4; k++) begin   // samples after N+2..N+5
         tests_run++;
         if (ctl_a[6] !== (k < 3) || busy_a !== (k < 3)) begin
            tests_failed++;
            $display("FAIL pulse_retrig[%0d]: bit6=%b busy=%b, need %b", k, ctl_a[6], busy_a, (k < 3));
         end
         @(negedge clock);
      end
      // A zero write at N+1 must not cancel.
      do_write(8'h40, 8'h40);  // N
      do_write(8'h00, 8'h40);  // N+1, returns after N+1
      for (int k = 0; k < 3; k++) begin   // samples after N+1..N+3
         tests_run++;
         if (ctl_a[6] !== (k < 2)) begin
            tests_failed++;
            $display("FAIL pulse_nocancel[%0d]: bit6=%b, need %b", k, ctl_a[6], (k < 2));
         end
         @(negedge clock);
      end
   endtask

   task automatic test_ext_clr();
      pulse_reset();
      @(negedge clock);
      do_write(8'hFF, 8'hFF);  // N0
      @(negedge clock);        // after N0+1: sync stages now 1
      ext_clr = 1'b1;
      do_write(8'hFF, 8'hFF);  // N0+2: clear collides with write
      ext_clr = 1'b0;
      tests_run++;
      if (ctl_a !== 8'h11 || rd_a !== 8'h11 || busy_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL ext_clr: control=%h rd=%h busy=%b, need 11 11 0", ctl_a, rd_a, busy_a);
      end
      // ExtReset=0: toggle bits flip back to 01, pulse reloads.
      tests_run++;
      if (ctl_nx !== 8'hDF || rd_nx !== 8'hDF || busy_nx !== 1'b1) begin
         tests_failed++;
         $display("FAIL ext_clr_ignored: control=%h rd=%h busy=%b, need df df 1", ctl_nx, rd_nx, busy_nx);
      end
      @(negedge clock);
      tests_run++;
      if (ctl_a !== 8'h11 || busy_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL ext_clr_hold: control=%h busy=%b, need 11 0", ctl_a, busy_a);
      end
   endtask

   task automatic test_reset_mid_pulse();
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      do_write(8'h40, 8'h40);  // N
      @(negedge clock);        // after N+1
      tests_run++;
      if (ctl_a[6] !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_pulse_pre: bit6=%b, need 1", ctl_a[6]);
      end
      #2 reset = 1'b0;
      #1;
      tests_run++;
      if (ctl_a[6] !== 1'b0 || busy_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_pulse_reset: bit6=%b busy=%b, need 0 0", ctl_a[6], busy_a);
      end
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         tests_run++;
         if (ctl_a !== 8'h11 || busy_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_pulse_noresume[%0d]: control=%h busy=%b, need 11 0", k, ctl_a, busy_a);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset   = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      wr_mask = '0;
      ext_clr = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      test_reset();
      test_direct_sync();
      test_toggle();
      test_pulse();
      test_ext_clr();
      test_reset_mid_pulse();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
